// File: rtl/req_shaper_pkg.sv
// Shared definitions for the request shaper: channel state encoding and
// client bit positions on the arbiter-facing buses.
package req_shaper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        GAP    = 2'b10
    } chan_state_t;

    // Bit index of each client on req/done/ovf/tmo/start/clr,
    // matching the arbiter's request ordering.
    localparam int C1 = 2;
    localparam int C2 = 1;
    localparam int C3 = 0;

    localparam int NUM_CLIENTS = 3;

endpackage

// File: rtl/req_chan.sv
// One client channel: length FIFO, burst FSM, grant/wait counters and
// sticky overflow/starvation flags.
module req_chan
    import req_shaper_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4,
    parameter int TMO_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             grant,
    input  logic             clr,
    output logic             req,
    output logic             done,
    output logic             ovf,
    output logic             tmo
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [TMO_W-1:0] WAIT_MAX = '1;

    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             push_drop;
    logic [LEN_W-1:0] len_eff;

    chan_state_t      state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [TMO_W-1:0] wait_reg, wait_next;
    logic             done_reg, done_next;
    logic             tmo_reg, tmo_set;
    logic             ovf_reg;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = (state_reg == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign push      = start && (!full || pop);
    assign push_drop = start && full && !pop;
    // A zero-length burst is treated as a single granted cycle.
    assign len_eff   = (len == '0) ? CNT_ONE : len;

    // FIFO pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage write; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= len_eff;
    end

    // Burst FSM next-state, counters and completion/starvation events.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wait_next  = wait_reg;
        done_next  = 1'b0;
        tmo_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    cnt_next   = mem[rd_ptr[AW-1:0]];
                    wait_next  = '0;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (grant) begin
                    cnt_next  = cnt_reg - 1'b1;
                    wait_next = '0;
                    if (cnt_reg == CNT_ONE) begin
                        state_next = GAP;
                        done_next  = 1'b1;
                    end
                end else begin
                    wait_next = (wait_reg == WAIT_MAX) ? wait_reg : wait_reg + 1'b1;
                    tmo_set   = (wait_next == WAIT_MAX);
                end
            end
            GAP: begin
                // Grants here are stale; the arbiter still sees the dropped request.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wait_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wait_reg  <= wait_next;
            done_reg  <= done_next;
        end
    end

    // Sticky flags; a set event in the same cycle overrides a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg <= 1'b0;
            tmo_reg <= 1'b0;
        end else begin
            if (push_drop)  ovf_reg <= 1'b1;
            else if (clr)   ovf_reg <= 1'b0;
            if (tmo_set)    tmo_reg <= 1'b1;
            else if (clr)   tmo_reg <= 1'b0;
        end
    end

    assign req  = (state_reg == ACTIVE);
    assign done = done_reg;
    assign ovf  = ovf_reg;
    assign tmo  = tmo_reg;

endmodule

// File: rtl/req_shaper.sv
// Three-client request conditioning stage in front of the arbiter: one
// req_chan per client, with per-client signals packed into 3-bit buses.
module req_shaper
    import req_shaper_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4,
    parameter int TMO_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       start,
    input  logic [LEN_W-1:0] len1,
    input  logic [LEN_W-1:0] len2,
    input  logic [LEN_W-1:0] len3,
    input  logic             g1,
    input  logic             g2,
    input  logic             g3,
    input  logic [2:0]       clr,
    output logic [2:0]       req,
    output logic [2:0]       done,
    output logic [2:0]       ovf,
    output logic [2:0]       tmo
);

    logic [LEN_W-1:0]       len_bus [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] grant_bus;

    assign len_bus[C1]   = len1;
    assign len_bus[C2]   = len2;
    assign len_bus[C3]   = len3;
    assign grant_bus[C1] = g1;
    assign grant_bus[C2] = g2;
    assign grant_bus[C3] = g3;

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_chan
            req_chan #(
                .LEN_W (LEN_W),
                .DEPTH (DEPTH),
                .TMO_W (TMO_W)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .start (start[gi]),
                .len   (len_bus[gi]),
                .grant (grant_bus[gi]),
                .clr   (clr[gi]),
                .req   (req[gi]),
                .done  (done[gi]),
                .ovf   (ovf[gi]),
                .tmo   (tmo[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_req_shaper.sv
// Directed bench for req_shaper: expected burst lengths are queued per client
// when a start is driven and checked against counted grants on each done pulse.
module tb_req_shaper;
    import req_shaper_pkg::*;

    localparam int LEN_W = 4;
    localparam int DEPTH = 4;
    localparam int TMO_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       start;
    logic [LEN_W-1:0] len1, len2, len3;
    logic             g1, g2, g3;
    logic [2:0]       clr;
    logic [2:0]       req, done, ovf, tmo;

    req_shaper #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len1  (len1),
        .len2  (len2),
        .len3  (len3),
        .g1    (g1),
        .g2    (g2),
        .g3    (g3),
        .clr   (clr),
        .req   (req),
        .done  (done),
        .ovf   (ovf),
        .tmo   (tmo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_q0[$];
    int exp_q1[$];
    int exp_q2[$];
    int n_done [3];
    int gcnt   [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input int l);
        case (k)
            2:       exp_q2.push_back(l);
            1:       exp_q1.push_back(l);
            default: exp_q0.push_back(l);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            2:       return exp_q2.size();
            1:       return exp_q1.size();
            default: return exp_q0.size();
        endcase
    endfunction

    function automatic int qpop(input int k);
        case (k)
            2:       return exp_q2.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q0.pop_front();
        endcase
    endfunction

    // Raise start[k] with length l; queue the expected granted-cycle count if accepted.
    task automatic set_start(input int k, input int l, input bit acc);
        start[k] = 1'b1;
        case (k)
            2:       len1 = LEN_W'(l);
            1:       len2 = LEN_W'(l);
            default: len3 = LEN_W'(l);
        endcase
        if (acc) push_exp(k, (l == 0) ? 1 : l);
    endtask

    // Scoreboard monitor: count granted requesting cycles, compare on done.
    initial begin
        logic [2:0] gv;
        int pending;
        int e;
        forever begin
            @(negedge clk);
            gv = {g1, g2, g3};
            if (reset) begin
                exp_q0.delete();
                exp_q1.delete();
                exp_q2.delete();
                for (int k = 0; k < 3; k++) gcnt[k] = 0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (req[k] && gv[k]) gcnt[k]++;
                    if (done[k]) begin
                        n_done[k]++;
                        pending = qsize(k);
                        check("sb_pending", pending != 0, 1);
                        if (pending != 0) begin
                            e = qpop(k);
                            check("burst_len", gcnt[k], e);
                            $display("[TB] t=%0t client bit %0d done, grants %0d expected %0d", $time, k, gcnt[k], e);
                        end
                        gcnt[k] = 0;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int owner;
        int nxt;
        int cand;
        int between;
        int c1_seen;
        bit seen_g3;
        logic [2:0] req_prev;

        reset = 1'b1;
        start = '0;
        clr   = '0;
        len1  = '0;
        len2  = '0;
        len3  = '0;
        g1    = 1'b0;
        g2    = 1'b0;
        g3    = 1'b0;

        // Reset state
        tick();
        check("rst_req",  req,  3'b000);
        check("rst_done", done, 3'b000);
        check("rst_ovf",  ovf,  3'b000);
        check("rst_tmo",  tmo,  3'b000);
        tick();
        reset = 1'b0;
        tick();

        // Single burst, client 1, length 3, grants t+4..t+6
        set_start(C1, 3, 1);
        tick(); start = '0;                       // t+1
        check("s1_req_t1", req, 3'b000);
        tick();                                   // t+2
        check("s1_req_t2", req, 3'b100);
        tick();                                   // t+3
        tick(); g1 = 1'b1;                        // t+4
        tick();                                   // t+5
        tick();                                   // t+6
        check("s1_req_t6", req, 3'b100);
        tick(); g1 = 1'b0;                        // t+7
        check("s1_req_t7", req, 3'b000);
        check("s1_done_t7", done, 3'b100);
        tick();
        check("s1_done_t8", done, 3'b000);

        // Zero length with grant held through GAP, client 2
        g2 = 1'b1;
        set_start(C2, 0, 1);
        tick(); start = '0;                       // t+1
        tick();                                   // t+2
        check("z_req_t2", req, 3'b010);
        tick();                                   // t+3
        check("z_req_t3", req, 3'b000);
        check("z_done_t3", done, 3'b010);
        tick();                                   // t+4
        check("z_done_t4", done, 3'b000);
        tick();                                   // t+5
        check("z_req_t5", req, 3'b000);
        g2 = 1'b0;

        // Overflow, client 3, no grants
        base = n_done[C3];
        for (int i = 1; i <= 5; i++) begin
            start = '0;
            set_start(C3, i, 1);
            tick();
        end
        start = '0;
        set_start(C3, 7, 0);                      // sixth start, FIFO full
        check("ovf_before", ovf, 3'b000);
        tick(); start = '0;
        check("ovf_set", ovf, 3'b001);
        clr = 3'b001;
        tick(); clr = '0;
        check("ovf_clr", ovf, 3'b000);
        g3 = 1'b1;
        repeat (40) tick();
        g3 = 1'b0;
        check("ovf_bursts", n_done[C3] - base, 5);

        // Starvation, client 3, length 3
        start = '0;
        set_start(C3, 3, 1);
        tick(); start = '0;                       // t+1
        tick();                                   // t+2
        check("st_req", req, 3'b001);
        repeat (62) tick();                       // t+64
        check("tmo_62", tmo, 3'b000);
        tick();                                   // t+65
        check("tmo_63", tmo, 3'b001);
        g3 = 1'b1;
        tick(); g3 = 1'b0;                        // t+66
        check("tmo_sticky", tmo, 3'b001);
        clr = 3'b001;
        tick(); clr = '0;                         // t+67
        check("tmo_clr", tmo, 3'b000);
        repeat (61) tick();                       // t+128
        check("tmo_wait_cleared", tmo, 3'b000);
        tick();                                   // t+129
        check("tmo_again", tmo, 3'b001);
        g3 = 1'b1;
        tick(); tick(); g3 = 1'b0;                // t+131
        check("st_done", done, 3'b001);

        // Reset mid-burst, client 1 length 8 with a second burst queued
        start = '0;
        set_start(C1, 8, 1);
        tick(); start = '0;                       // t+1
        set_start(C1, 5, 1);
        tick(); start = '0;                       // t+2
        tick(); g1 = 1'b1;                        // t+3
        tick(); tick(); tick(); g1 = 1'b0;        // t+6, three grants seen
        check("mr_req_before", req, 3'b100);
        #1 reset = 1'b1;
        #1;
        check("mr_req",  req,  3'b000);
        check("mr_done", done, 3'b000);
        check("mr_ovf",  ovf,  3'b000);
        check("mr_tmo",  tmo,  3'b000);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("mr_fifo_empty", req, 3'b000);
        set_start(C1, 2, 1);
        tick(); start = '0;                       // u+1
        check("mr_lat_u1", req, 3'b000);
        tick();                                   // u+2
        check("mr_lat_u2", req, 3'b100);
        g1 = 1'b1;
        tick(); tick(); g1 = 1'b0;                // u+4
        check("mr_done_new", done, 3'b100);
        tick();

        // Closed loop: clients 1 and 3 against a round-robin arbiter model
        owner    = -1;
        req_prev = '0;
        between  = 0;
        c1_seen  = 0;
        seen_g3  = 1'b0;
        base     = n_done[C3];
        nxt      = n_done[C1];
        for (int c = 0; c < 200; c++) begin
            start = '0;
            if (c < 2) begin
                set_start(C1, 2, 1);
                set_start(C3, 2, 1);
            end else begin
                if (done[C1]) set_start(C1, 2, 1);
                if (done[C3]) set_start(C3, 2, 1);
            end
            if (done[C1]) begin
                if (c1_seen > 0 && seen_g3) between++;
                c1_seen++;
                seen_g3 = 1'b0;
            end
            // Grant follows the previous cycle's requests; owner keeps it while requesting.
            if (!(owner >= 0 && req_prev[owner])) begin
                int from;
                from = (owner < 0) ? 3 : owner;
                owner = -1;
                for (int i = 1; i <= 3; i++) begin
                    cand = (from - i + 3) % 3;
                    if (owner < 0 && req_prev[cand]) owner = cand;
                end
            end
            {g1, g2, g3} = (owner >= 0) ? (3'b001 << owner) : 3'b000;
            if (req[C3] && g3) seen_g3 = 1'b1;
            req_prev = req;
            tick();
        end
        start = '0;
        {g1, g2, g3} = 3'b000;
        check("cl_c1_progress", (n_done[C1] - nxt) >= 10, 1);
        check("cl_c3_progress", (n_done[C3] - base) >= 10, 1);
        check("cl_g3_between", between > 0, 1);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
